imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the LEGv8 datapath: classifies a 32-bit instruction,
//  extracts its immediate and sign/zero-extends it to N bits. Sits between fetch and execute in the
//  pipelined core; valid/ready on both sides, 2-stage latency, 1 instr/cycle throughput. Adds B, I and
//  IW formats, a format tag, flush and a saturating count of unrecognised opcodes.
// PARAMETERS
//  N      64  output immediate width; legal N >= 32
//  ERR_W  8   width of unrecognised-opcode counter
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      sync: drop both stages' contents
//  in_valid   in   1      instr valid
//  in_ready   out  1      block can accept instr this cycle
//  instr      in   32     instruction word
//  out_valid  out  1      imm/fmt valid
//  out_ready  in   1      consumer takes imm this cycle
//  imm        out  N      extended immediate
//  fmt        out  3      imm_fmt_e tag of imm
//  err_cnt    out  ERR_W  count of accepted unrecognised instrs, saturating
// BEHAVIOUR
//  Reset (async, any time incl. mid-transfer): s1_valid=s2_valid=0, out_valid=0, imm=0, fmt=FMT_NONE, err_cnt=0.
//  Stages: S1 registers instr + decoded fmt; S2 registers extended imm + fmt. out_valid=s2_valid.
//  Advance: s2_adv = !s2_valid | out_ready; s1_adv = s2_adv; in_ready = (!s1_valid | s1_adv) & !flush.
//  Accept when in_valid & in_ready. Latency: accepted cycle t -> out_valid at t+2 if out_ready held.
//  Back-pressure: out_ready=0 holds S2 and S1 stable; imm/fmt must not change while out_valid & !out_ready.
//  Decode on instr[31:21] (priority top-down, ? = don't care):
//   1111_1000_010 LDUR, 1111_1000_000 STUR -> FMT_D : sext(instr[20:12])
//   1011_010?_??? CBZ/CBNZ                 -> FMT_CB: sext(instr[23:5])
//   0001_01??_??? B                        -> FMT_B : sext(instr[25:0])
//   1?01_0001_00? ADDI/SUBI                -> FMT_I : zext(instr[21:10])
//   1101_0010_1?? MOVZ                     -> FMT_IW: zext(instr[20:5]) << (16*instr[22:21])
//   anything else                          -> FMT_NONE: imm=0, counts as unrecognised
//  IW shift result truncated to N bits (N=32 with hw>=2 yields 0).
//  err_cnt += 1 on acceptance of a FMT_NONE instr; holds at 2**ERR_W-1; flush does not clear it.
//  flush=1: next edge s1_valid=s2_valid=0; in_ready=0 that cycle so an offered instr is not accepted
//   and not counted; flush with out_ready=1 still drops S2 (consumer sees at most the current beat).
//  imm/fmt registers hold last value when stages empty (no reset-to-zero on drain).
// CONFIGURATION
//  IMMEXT_BRANCH_SHIFT_EN defined: FMT_CB and FMT_B immediates are emitted pre-shifted left by 2
//   (byte offset, sext(field)<<2). Undefined: emitted as raw word offsets. D/I/IW unaffected either way.
// STRUCTURE
//  Package imm_pkg: typedef enum logic [2:0] imm_fmt_e {FMT_NONE,FMT_D,FMT_CB,FMT_B,FMT_I,FMT_IW};
//   opcode match constants (OP_LDUR, OP_STUR, OP_CBZ_PFX, OP_B_PFX, OP_ADDI, OP_SUBI, OP_MOVZ_PFX).
//  Sub-module imm_classify: combinational instr[31:21] -> imm_fmt_e, instantiated in S1 input path.
//  Extension mux lives in top, between S1 and S2 registers.
// TESTING
//  1 LDUR 0xF85F8000 (imm9=-8), out_ready=1 -> 2 cycles later imm=64'hFFFF_FFFF_FFFF_FFF8, fmt=FMT_D.
//  2 CBZ 0xB4FFFFE0 (imm19=-1) -> imm=all-ones; with IMMEXT_BRANCH_SHIFT_EN imm=64'hFFFF_FFFF_FFFF_FFFC.
//  3 MOVZ 0xD2E24680 (hw=3, imm16=0x1234) -> imm=64'h1234_0000_0000_0000, fmt=FMT_IW; N=32 -> imm=0.
//  4 Stream 4 instrs, out_ready low cycles 3-5 -> in_ready=0 once S1,S2 full; outputs in order, none
//    lost/duplicated, imm stable while stalled.
//  5 0x00000000 x300 with ERR_W=8 -> err_cnt reaches 255 and holds; fmt=FMT_NONE, imm=0 each beat.
//  6 Both stages full, flush=1 with in_valid=1 -> next cycle out_valid=0, err_cnt unchanged; reset
//    asserted mid-stream mid-cycle -> outputs zero immediately, no output beat after release.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode match constants for the LEGv8 immediate generator.
// Opcode constants are compared against the top bits of instr[31:21]; the
// prefix constants cover only the fixed bits of their encoding.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } imm_fmt_e;

    // Full 11-bit opcodes (instr[31:21])
    localparam logic [10:0] OP_LDUR     = 11'b1111_1000_010;
    localparam logic [10:0] OP_STUR     = 11'b1111_1000_000;
    // CBZ/CBNZ: instr[31:25]
    localparam logic [6:0]  OP_CBZ_PFX  = 7'b1011_010;
    // B: instr[31:26]
    localparam logic [5:0]  OP_B_PFX    = 6'b0001_01;
    // ADDI/SUBI: instr[31:22]
    localparam logic [9:0]  OP_ADDI     = 10'b1001_0001_00;
    localparam logic [9:0]  OP_SUBI     = 10'b1101_0001_00;
    // MOVZ: instr[31:23]
    localparam logic [8:0]  OP_MOVZ_PFX = 9'b1101_0010_1;

endpackage

// File: rtl/imm_classify.sv
// Combinational instruction classifier: maps instr[31:21] to the immediate
// format tag. Encodings are tested top-down so earlier rows win on overlap.
module imm_classify
    import imm_pkg::*;
(
    input  logic [10:0] i_op,
    output logic [2:0]  o_fmt
);

    // Priority decode of the opcode field into a format tag
    always_comb begin
        // NOTE: defaulting the output first keeps every path assigned, so no latch is inferred.
        o_fmt = FMT_NONE;
        if (i_op == OP_LDUR || i_op == OP_STUR) begin
            o_fmt = FMT_D;
        end else if (i_op[10:4] == OP_CBZ_PFX) begin
            o_fmt = FMT_CB;
        end else if (i_op[10:5] == OP_B_PFX) begin
            o_fmt = FMT_B;
        end else if (i_op[10:1] == OP_ADDI || i_op[10:1] == OP_SUBI) begin
            o_fmt = FMT_I;
        end else if (i_op[10:2] == OP_MOVZ_PFX) begin
            o_fmt = FMT_IW;
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage pipelined immediate generator for the LEGv8 datapath.
// S1 holds the instruction and its decoded format, S2 holds the extended
// immediate and format. Valid/ready on both sides, one instruction per cycle.
// Optional feature: define IMMEXT_BRANCH_SHIFT_EN to emit CB/B immediates as
// byte offsets (sign-extended field shifted left by 2) instead of word offsets.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int N     = 64,
    parameter int ERR_W = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     imm,
    output logic [2:0]       fmt,
    output logic [ERR_W-1:0] err_cnt
);

    // Stage 1: only instr[25:0] is needed once the format is known
    logic             r_s1_valid;
    logic [25:0]      r_s1_instr;
    imm_fmt_e         r_s1_fmt;

    // Stage 2: extended immediate and its tag
    logic             r_s2_valid;
    logic [N-1:0]     r_imm;
    imm_fmt_e         r_fmt;

    logic [ERR_W-1:0] r_err_cnt;

    logic [2:0]       w_in_fmt_raw;
    imm_fmt_e         w_in_fmt;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_s1_load;
    logic             w_accept;
    logic [N-1:0]     w_iw_base;
    logic [N-1:0]     w_imm_ext;

    imm_classify u_classify (
        .i_op  (instr[31:21]),
        .o_fmt (w_in_fmt_raw)
    );

    assign w_in_fmt  = imm_fmt_e'(w_in_fmt_raw);

    // A stage advances when the one downstream of it can take its contents
    assign w_s2_adv  = !r_s2_valid | out_ready;
    assign w_s1_adv  = w_s2_adv;
    assign w_s1_load = !r_s1_valid | w_s1_adv;
    assign in_ready  = (!r_s1_valid | w_s1_adv) & !flush;
    assign w_accept  = in_valid & in_ready;

    // MOVZ payload before the halfword shift; shifting by 16*hw past N bits yields 0
    assign w_iw_base = {{(N-16){1'b0}}, r_s1_instr[20:5]};

    // Extend the S1 field selected by its format to N bits
    always_comb begin
        w_imm_ext = '0;
        case (r_s1_fmt)
            FMT_D:  w_imm_ext = {{(N-9){r_s1_instr[20]}}, r_s1_instr[20:12]};
`ifdef IMMEXT_BRANCH_SHIFT_EN
            FMT_CB: w_imm_ext = {{(N-21){r_s1_instr[23]}}, r_s1_instr[23:5], 2'b00};
            FMT_B:  w_imm_ext = {{(N-28){r_s1_instr[25]}}, r_s1_instr[25:0], 2'b00};
`else
            FMT_CB: w_imm_ext = {{(N-19){r_s1_instr[23]}}, r_s1_instr[23:5]};
            FMT_B:  w_imm_ext = {{(N-26){r_s1_instr[25]}}, r_s1_instr[25:0]};
`endif
            FMT_I:  w_imm_ext = {{(N-12){1'b0}}, r_s1_instr[21:10]};
            FMT_IW: w_imm_ext = w_iw_base << {r_s1_instr[22:21], 4'b0000};
            default: w_imm_ext = '0;
        endcase
    end

    // S1 register: capture accepted instruction, empty on flush or when drained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are reset too, so reset leaves no X on any stage.
            r_s1_valid <= 1'b0;
            r_s1_instr <= '0;
            r_s1_fmt   <= FMT_NONE;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_instr <= instr[25:0];
                r_s1_fmt   <= w_in_fmt;
            end
        end
    end

    // S2 register: take S1 contents on advance; imm/fmt hold when nothing arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_imm      <= '0;
            r_fmt      <= FMT_NONE;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_imm <= w_imm_ext;
                r_fmt <= r_s1_fmt;
            end
        end
    end

    // Saturating count of accepted unrecognised instructions; flush leaves it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_in_fmt == FMT_NONE && r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign imm       = r_imm;
    assign fmt       = r_fmt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: a 64-bit and a 32-bit instance share
// stimulus; a queue-based reference model predicts every output beat.
module tb_imm_ext_pipe;

    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_D    = 3'd1;
    localparam logic [2:0] F_CB   = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_I    = 3'd4;
    localparam logic [2:0] F_IW   = 3'd5;
    localparam int         ERR_MAX = 255;

    typedef struct {
        logic [63:0] imm;
        logic [31:0] imm32;
        logic [2:0]  fmt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;

    logic        in_ready,  in_ready32;
    logic        out_valid, out_valid32;
    logic [63:0] imm;
    logic [31:0] imm32;
    logic [2:0]  fmt, fmt32;
    logic [7:0]  err_cnt, err_cnt32;

    int   n_checks;
    int   n_errors;
    exp_t q[$];
    int   err_model;
    bit   stalled;
    logic [63:0] stall_imm;
    logic [2:0]  stall_fmt;

    imm_ext_pipe #(.N(64), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fmt(fmt), .err_cnt(err_cnt)
    );

    imm_ext_pipe #(.N(32), .ERR_W(8)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .instr(instr),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .fmt(fmt32), .err_cnt(err_cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: decode straight from the encoding table, extend with integer arithmetic
    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        longint      v;
        logic [10:0] op;
        int          hw;
        op    = ins[31:21];
        v     = 0;
        e.fmt = F_NONE;
        casez (op)
            11'b1111_1000_010, 11'b1111_1000_000: begin
                e.fmt = F_D;
                v = longint'(ins[20:12]);
                if (v >= 256) v = v - 512;
            end
            11'b1011_010?_???: begin
                e.fmt = F_CB;
                v = longint'(ins[23:5]);
                if (v >= 262144) v = v - 524288;
`ifdef IMMEXT_BRANCH_SHIFT_EN
                v = v * 4;
`endif
            end
            11'b0001_01??_???: begin
                e.fmt = F_B;
                v = longint'(ins[25:0]);
                if (v >= 33554432) v = v - 67108864;
`ifdef IMMEXT_BRANCH_SHIFT_EN
                v = v * 4;
`endif
            end
            11'b1?01_0001_00?: begin
                e.fmt = F_I;
                v = longint'(ins[21:10]);
            end
            11'b1101_0010_1??: begin
                e.fmt = F_IW;
                hw = int'(ins[22:21]);
                v = longint'(ins[20:5]) << (16 * hw);
            end
            default: v = 0;
        endcase
        e.imm   = v;
        e.imm32 = e.imm[31:0];
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = {11'b1111_1000_010, r[20:0]};
            1: r = {11'b1111_1000_000, r[20:0]};
            2: r = {7'b1011_010, r[24:0]};
            3: r = {6'b0001_01, r[25:0]};
            4: r = {1'b1, r[31], 8'b0100_0100, r[21:0]};
            5: r = {9'b1101_0010_1, r[22:0]};
            default: r = r;
        endcase
        return r;
    endfunction

    // One clock of stimulus; scoreboards the output beat and records acceptance
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                        input logic fl, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        instr     = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        n_checks++;
        if (err_cnt !== 8'(err_model)) begin
            n_errors++;
            $display("FAIL err_cnt: got %0d expected %0d", err_cnt, err_model);
        end
        n_checks++;
        if (out_valid32 !== out_valid || in_ready32 !== in_ready || err_cnt32 !== err_cnt || fmt32 !== fmt) begin
            n_errors++;
            $display("FAIL n32_sync: ov32=%b ov=%b ir32=%b ir=%b", out_valid32, out_valid, in_ready32, in_ready);
        end
        if (stalled) begin
            n_checks++;
            if (out_valid !== 1'b1 || imm !== stall_imm || fmt !== stall_fmt) begin
                n_errors++;
                $display("FAIL stall_hold: ov=%b imm=%h fmt=%0d expected ov=1 imm=%h fmt=%0d",
                         out_valid, imm, fmt, stall_imm, stall_fmt);
            end
        end
        if (out_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL spurious_beat: out_valid=1 with no instruction outstanding (imm=%h)", imm);
            end else begin
                e = q[0];
                if (imm !== e.imm || imm32 !== e.imm32 || fmt !== e.fmt) begin
                    n_errors++;
                    $display("FAIL beat: imm=%h imm32=%h fmt=%0d expected imm=%h imm32=%h fmt=%0d",
                             imm, imm32, fmt, e.imm, e.imm32, e.fmt);
                end
                if (ordy) void'(q.pop_front());
            end
        end
        stalled   = (out_valid === 1'b1) && !ordy && !fl;
        stall_imm = imm;
        stall_fmt = fmt;
        acc = v && (in_ready === 1'b1);
        if (acc) begin
            e = model(ins);
            q.push_back(e);
            if (e.fmt == F_NONE && err_model < ERR_MAX) err_model++;
        end
        if (fl) q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = '0;
        q.delete(); err_model = 0; stalled = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 10 && q.size() != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d beats still outstanding after timeout", q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = '0;
        q.delete(); err_model = 0; stalled = 0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imm !== 64'h0 || fmt !== F_NONE || err_cnt !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_state: ov=%b imm=%h fmt=%0d err=%0d expected all zero",
                     out_valid, imm, fmt, err_cnt);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Send one instruction with the consumer ready; check 2-cycle latency and the value
    task automatic send_one(input string name, input logic [31:0] ins,
                            input logic [63:0] exp_imm, input logic [31:0] exp_imm32,
                            input logic [2:0] exp_fmt);
        logic acc;
        step(1'b1, ins, 1'b1, 1'b0, acc);
        n_checks++;
        if (acc !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_accept: in_ready=%b expected 1", name, in_ready);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_latency1: out_valid=%b expected 0", name, out_valid);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++;
        if (out_valid !== 1'b1 || imm !== exp_imm || imm32 !== exp_imm32 || fmt !== exp_fmt) begin
            n_errors++;
            $display("FAIL %s_value: ov=%b imm=%h imm32=%h fmt=%0d expected ov=1 imm=%h imm32=%h fmt=%0d",
                     name, out_valid, imm, imm32, fmt, exp_imm, exp_imm32, exp_fmt);
        end
    endtask

    task automatic test_ldur();
        send_one("ldur", 32'hF85F_8000, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, F_D);
    endtask

    task automatic test_cbz();
`ifdef IMMEXT_BRANCH_SHIFT_EN
        send_one("cbz", 32'hB4FF_FFE0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, F_CB);
`else
        send_one("cbz", 32'hB4FF_FFE0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, F_CB);
`endif
    endtask

    task automatic test_movz();
        send_one("movz", 32'hD2E2_4680, 64'h1234_0000_0000_0000, 32'h0, F_IW);
        send_one("addi", 32'h9100_0FFF | 32'h003F_FC00, 64'h0000_0000_0000_0FFF, 32'h0000_0FFF, F_I);
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   k;
        logic [31:0] ins [4];
        for (int i = 0; i < 4; i++) ins[i] = rand_instr();
        k = 0;
        for (int c = 0; c < 16; c++) begin
            step(k < 4, (k < 4) ? ins[k] : 32'h0, !(c >= 3 && c <= 5), 1'b0, acc);
            if (c >= 3 && c <= 5) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_backpressure: cycle %0d in_ready=%b expected 0", c, in_ready);
                end
            end
            if (acc) k++;
        end
        n_checks++;
        if (k != 4 || q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_count: accepted %0d outstanding %0d expected 4 and 0", k, q.size());
        end
    endtask

    task automatic test_err_sat();
        logic acc;
        apply_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 32'h0, 1'b1, 1'b0, acc);
        drain();
        n_checks++;
        if (err_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL err_saturate: err_cnt=%0d expected 255", err_cnt);
        end
    endtask

    task automatic test_flush();
        logic acc;
        int   err_before;
        apply_reset();
        // Both stages full, consumer stalled
        step(1'b1, rand_instr(), 1'b0, 1'b0, acc);
        step(1'b1, rand_instr(), 1'b0, 1'b0, acc);
        err_before = err_model;
        step(1'b1, 32'h0, 1'b0, 1'b1, acc);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_in_ready: in_ready=%b expected 0", in_ready);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'(err_before)) begin
            n_errors++;
            $display("FAIL flush_drop: ov=%b err=%0d expected ov=0 err=%0d", out_valid, err_cnt, err_before);
        end
        // Flush while the consumer takes the current beat: the rest is dropped
        step(1'b1, rand_instr(), 1'b1, 1'b0, acc);
        step(1'b1, rand_instr(), 1'b1, 1'b0, acc);
        step(1'b1, rand_instr(), 1'b1, 1'b0, acc);
        step(1'b1, 32'h0, 1'b1, 1'b1, acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_ready_drop: ov=%b expected 0", out_valid);
        end
        drain();
    endtask

    task automatic test_random();
        logic acc;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0, acc);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic acc;
        step(1'b1, rand_instr(), 1'b0, 1'b0, acc);
        step(1'b1, rand_instr(), 1'b0, 1'b0, acc);
        step(1'b1, 32'h0, 1'b0, 1'b0, acc);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imm !== 64'h0 || fmt !== F_NONE || err_cnt !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_mid: ov=%b imm=%h fmt=%0d err=%0d expected all zero",
                     out_valid, imm, fmt, err_cnt);
        end
        q.delete(); err_model = 0; stalled = 0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_release: ov=%b expected 0", out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_ldur();
        test_cbz();
        test_movz();
        test_back_to_back();
        test_err_sat();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
